writeback_ctrl: RTL

Parametrised successor to the single-register writeback stage. Holds the architectural PC and commits one instruction per accepted handshake: PC update, register-file write, retire count. Adds a valid/ready handshake, redirect override, halt/resume state machine, and a configurable reset vector. Sits at the end of the RISC pipeline, between execute/memory and the register file.

---
 rtl/writeback_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/writeback_ctrl.sv
// Writeback/commit stage: holds the architectural PC, retires one instruction per
// accepted handshake, and drives a registered register-file write port.

// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | accepting commits (in_ready=1)
// ST_HALTED | halt retired; upstream ignored until redirect_valid or reset
module writeback_ctrl #(
   parameter int                   WIDTH    = 32,
   parameter int                   RA_W     = 5,
   parameter logic [WIDTH-1:0]     RESET_PC = '0,
   parameter int                   CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    rstd,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        nextpc,
   input  logic                    wb_en,
   input  logic [RA_W-1:0]         wb_addr,
   input  logic [WIDTH-1:0]        wb_data,
   input  logic                    halt,
   input  logic                    redirect_valid,
   input  logic [WIDTH-1:0]        redirect_pc,
   output logic [WIDTH-1:0]        pc,
   output logic                    rf_we,
   output logic [RA_W-1:0]         rf_waddr,
   output logic [WIDTH-1:0]        rf_wdata,
   output logic [CNT_W-1:0]        retired,
   output logic                    halted
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_pc;
   logic               r_rf_we;
   logic [RA_W-1:0]    r_rf_waddr;
   logic [WIDTH-1:0]   r_rf_wdata;
   logic [CNT_W-1:0]   r_retired;
   logic               w_commit;

   assign w_commit = in_valid & (r_state == ST_RUN);

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_PC;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_retired  <= '0;
      end else begin
         r_rf_we <= 1'b0;
         if (w_commit) begin
            r_retired  <= r_retired + CNT_W'(1);
            r_rf_we    <= wb_en & (wb_addr != '0);
            r_rf_waddr <= wb_addr;
            r_rf_wdata <= wb_data;
         end

         // Redirect overrides the sequential PC even when a commit lands on the same edge
         if (redirect_valid)
            r_pc <= redirect_pc;
         else if (w_commit)
            r_pc <= nextpc;

         case (r_state)
            ST_RUN:    if (w_commit && halt) r_state <= ST_HALTED;
            ST_HALTED: if (redirect_valid)   r_state <= ST_RUN;
            default:                         r_state <= ST_RUN;
         endcase
      end
   end

   assign in_ready = (r_state == ST_RUN);
   assign halted   = (r_state == ST_HALTED);
   assign pc       = r_pc;
   assign rf_we    = r_rf_we;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;
   assign retired  = r_retired;

endmodule
